// File: rtl/mux_sel_pkg.sv
// mux_sel_pkg: shared types and constants for the 4-channel mux select arbiter
package mux_sel_pkg;
   typedef enum logic {IDLE, GRANT} state_t;
   localparam int NCH  = 4;
   localparam int SELW = 2;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin pick, first set req bit scanning from ptr upward mod 4
// ports: ptr - scan start; req - requests; idx - chosen channel; found - any request set
module rr_pick4
   import mux_sel_pkg::*;
(
   input  logic [SELW-1:0] ptr,
   input  logic [NCH-1:0]  req,
   output logic [SELW-1:0] idx,
   output logic            found
);
   logic [NCH-1:0]  rot;
   logic [SELW-1:0] off;
   always_comb begin
      rot = NCH'({req, req} >> ptr);
      off = '0;
      // descending scan so the lowest rotated bit (closest to ptr) wins
      for (int i = NCH - 1; i >= 0; i--) off = rot[i] ? SELW'(i) : off;
      idx   = ptr + off;
      found = |req;
   end
endmodule

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin arbiter with min dwell / max hold driving a 4:1 mux select
// ports: clk, rst (sync active-high), en, req[3:0] in; s1/s0 select, gnt one-hot,
//        gnt_valid, done (pulse the cycle after a grant ends) out, all registered
module mux_sel_arbiter
   import mux_sel_pkg::*;
#(
   parameter int DWELL   = 4,
   parameter int MAXHOLD = 16,
   parameter int CW      = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [NCH-1:0] req,
   output logic           s1,
   output logic           s0,
   output logic [NCH-1:0] gnt,
   output logic           gnt_valid,
   output logic           done
);
   state_t          state_q, state_d;
   logic [SELW-1:0] ptr_q, ptr_d, sel_q, sel_d, pick_ptr, pick_idx;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NCH-1:0]  gnt_q, gnt_d;
   logic            valid_q, valid_d, done_q, done_d;
   logic            pick_found, rel, start, at_max;

   // during a grant the pick must start past the current owner so release rotates
   assign pick_ptr = (state_q == GRANT) ? sel_q + 1'b1 : ptr_q;

   rr_pick4 u_pick (
      .ptr   (pick_ptr),
      .req   (req),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      at_max  = cnt_q == CW'(MAXHOLD - 1);
      rel     = (state_q == GRANT) && (!en || at_max || (cnt_q >= CW'(DWELL - 1) && !req[sel_q]));
      start   = en && pick_found && (state_q == IDLE || rel);
      state_d = start ? GRANT : (rel ? IDLE : state_q);
      ptr_d   = rel ? sel_q + 1'b1 : ptr_q;
      sel_d   = start ? pick_idx : sel_q;
      cnt_d   = (start || rel) ? '0 : ((state_q == GRANT && !at_max) ? cnt_q + 1'b1 : cnt_q);
      valid_d = state_d == GRANT;
      gnt_d   = valid_d ? ({{(NCH - 1){1'b0}}, 1'b1} << sel_d) : '0;
      done_d  = rel;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign s1        = sel_q[1];
   assign s0        = sel_q[0];
   assign gnt       = gnt_q;
   assign gnt_valid = valid_q;
   assign done      = done_q;
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: directed table-driven bench for mux_sel_arbiter (DWELL=4, MAXHOLD=16)
module tb_mux_sel_arbiter;
   logic       clk = 1'b0, rst = 1'b1, en = 1'b0;
   logic [3:0] req = 4'b0000;
   logic       s1, s0, gnt_valid, done;
   logic [3:0] gnt;
   int total = 0, bad = 0;

   typedef struct {
      logic       rst;
      logic       en;
      logic [3:0] req;
      logic [8:0] exp;
   } vec_t;

   vec_t tbl[29];

   mux_sel_arbiter #(.DWELL(4), .MAXHOLD(16), .CW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .s1        (s1),
      .s0        (s0),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .done      (done)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] e(input logic [1:0] sel, input logic [3:0] g, input logic v, input logic d);
      return {sel, g, v, d};
   endfunction

   function automatic vec_t mk(input logic r, input logic n, input logic [3:0] q, input logic [8:0] x);
      vec_t t;
      t.rst = r;
      t.en  = n;
      t.req = q;
      t.exp = x;
      return t;
   endfunction

   task automatic step(input logic r, input logic n, input logic [3:0] q);
      @(negedge clk);
      rst = r;
      en  = n;
      req = q;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int idx, input logic [8:0] exp);
      logic [8:0] act;
      act = {s1, s0, gnt, gnt_valid, done};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got {s1s0,gnt,v,d}=%b_%b_%b_%b want %b_%b_%b_%b",
                  name, idx, act[8:7], act[6:3], act[2], act[1 -: 1], exp[8:7], exp[6:3], exp[2], exp[1 -: 1]);
         if (act[0] !== exp[0]) $display("FAIL %s[%0d]: done got %b want %b", name, idx, act[0], exp[0]);
      end
   endtask

   initial begin
      // reset with requests pending, then first grant to ch0
      tbl[0]  = mk(1, 1, 4'b1111, e(0, 4'b0000, 0, 0));
      tbl[1]  = mk(1, 1, 4'b1111, e(0, 4'b0000, 0, 0));
      tbl[2]  = mk(0, 1, 4'b1111, e(0, 4'b0001, 1, 0));
      tbl[3]  = mk(0, 0, 4'b0000, e(0, 4'b0000, 0, 1));
      tbl[4]  = mk(0, 0, 4'b0000, e(0, 4'b0000, 0, 0));
      // dwell: ch2 requests one cycle, held exactly 4 cycles
      tbl[5]  = mk(0, 1, 4'b0100, e(2, 4'b0100, 1, 0));
      tbl[6]  = mk(0, 1, 4'b0000, e(2, 4'b0100, 1, 0));
      tbl[7]  = mk(0, 1, 4'b0000, e(2, 4'b0100, 1, 0));
      tbl[8]  = mk(0, 1, 4'b0000, e(2, 4'b0100, 1, 0));
      tbl[9]  = mk(0, 1, 4'b0000, e(2, 4'b0000, 0, 1));
      tbl[10] = mk(0, 1, 4'b0000, e(2, 4'b0000, 0, 0));
      // skip and wrap: ptr=3, req=0011 -> ch0, then back-to-back ch1
      tbl[11] = mk(0, 1, 4'b0011, e(0, 4'b0001, 1, 0));
      tbl[12] = mk(0, 1, 4'b0010, e(0, 4'b0001, 1, 0));
      tbl[13] = mk(0, 1, 4'b0010, e(0, 4'b0001, 1, 0));
      tbl[14] = mk(0, 1, 4'b0010, e(0, 4'b0001, 1, 0));
      tbl[15] = mk(0, 1, 4'b0010, e(1, 4'b0010, 1, 1));
      // forced release of ch1 at cnt=1, no new grant while en=0
      tbl[16] = mk(0, 1, 4'b0010, e(1, 4'b0010, 1, 0));
      tbl[17] = mk(0, 0, 4'b0010, e(1, 4'b0000, 0, 1));
      tbl[18] = mk(0, 0, 4'b1111, e(1, 4'b0000, 0, 0));
      // ch3 grant, reset at cnt=5, ptr back to 0
      tbl[19] = mk(0, 1, 4'b1000, e(3, 4'b1000, 1, 0));
      tbl[20] = mk(0, 1, 4'b1000, e(3, 4'b1000, 1, 0));
      tbl[21] = mk(0, 1, 4'b1000, e(3, 4'b1000, 1, 0));
      tbl[22] = mk(0, 1, 4'b1000, e(3, 4'b1000, 1, 0));
      tbl[23] = mk(0, 1, 4'b1000, e(3, 4'b1000, 1, 0));
      tbl[24] = mk(0, 1, 4'b1000, e(3, 4'b1000, 1, 0));
      tbl[25] = mk(1, 1, 4'b1000, e(0, 4'b0000, 0, 0));
      tbl[26] = mk(0, 1, 4'b1111, e(0, 4'b0001, 1, 0));
      tbl[27] = mk(0, 0, 4'b1111, e(0, 4'b0000, 0, 1));
      tbl[28] = mk(0, 0, 4'b1111, e(0, 4'b0000, 0, 0));

      for (int i = 0; i < 29; i++) begin
         step(tbl[i].rst, tbl[i].en, tbl[i].req);
         check("vec", i, tbl[i].exp);
      end

      // round robin under full load: each grant ends at MAXHOLD, order 0,1,2,3,0
      step(1, 0, 4'b1111);
      check("rr_rst", 0, e(0, 4'b0000, 0, 0));
      for (int j = 0; j < 80; j++) begin
         logic [1:0] ch;
         ch = 2'((j / 16) % 4);
         step(0, 1, 4'b1111);
         check("rr", j, e(ch, 4'b0001 << ch, 1, (j > 0) && (j % 16 == 0)));
      end
      step(0, 0, 4'b1111);
      check("rr_end", 0, e(0, 4'b0000, 0, 1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
